// File: rtl/uart_rx_pkg.sv
// Shared constants for the oversampling UART receiver: FSM encoding, parity
// selection and the prescale floor.
package uart_rx_pkg;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int unsigned MIN_PRESCALE = 8;

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter with a 3-sample window around mid-bit and a 2-of-3 majority vote.
module uart_rx_sampler #(
    parameter int unsigned PRESC_W = 6
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               run,
    input  logic               restart,
    input  logic [PRESC_W-1:0] prescale,
    input  logic               rx_in,
    output logic               edge_last,
    output logic               sampled_bit
);

    logic [PRESC_W-1:0] edge_q;
    logic [PRESC_W-1:0] half;
    logic [PRESC_W-1:0] last;
    logic [2:0]         samp_q;
    logic               in_window;

    assign half = prescale >> 1;
    assign last = prescale - PRESC_W'(1);

    assign in_window = run && ((edge_q == half - PRESC_W'(2)) ||
                               (edge_q == half - PRESC_W'(1)) ||
                               (edge_q == half));

    assign edge_last   = run && (edge_q == last);
    assign sampled_bit = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) |
                         (samp_q[1] & samp_q[2]);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            edge_q <= '0;
            samp_q <= '0;
        end else begin
            // The detect cycle is edge 0 of the start bit, so counting resumes at 1.
            if (restart) begin
                edge_q <= PRESC_W'(1);
            end else if (run && (edge_q != last)) begin
                edge_q <= edge_q + PRESC_W'(1);
            end else begin
                edge_q <= '0;
            end
            if (in_window) begin
                samp_q <= {samp_q[1:0], rx_in};
            end
        end
    end

endmodule

// File: rtl/uart_rx_frame.sv
// Oversampling UART receiver: start detection, frame FSM, parity/stop checking and
// registered result pulses.
module uart_rx_frame
    import uart_rx_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned PRESC_W = 6
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               RX_IN,
    input  logic               PAR_EN,
    input  logic               PAR_TYP,
    input  logic [PRESC_W-1:0] Prescale,
    output logic [WIDTH-1:0]   P_DATA,
    output logic               DATA_VLD,
    output logic               PAR_ERR,
    output logic               STP_ERR
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [2:0]         state_q, state_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0]   word_q, word_d;
    logic [WIDTH-1:0]   p_data_q, p_data_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               par_en_q, par_en_d;
    logic               par_typ_q, par_typ_d;
    logic               par_fail_q, par_fail_d;
    logic               vld_q, vld_d;
    logic               perr_q, perr_d;
    logic               serr_q, serr_d;
    logic               rx_prev_q;

    logic               detect;
    logic               edge_last;
    logic               sampled_bit;
    logic [PRESC_W-1:0] presc_eff;

    assign detect = (state_q == IDLE) && !RX_IN && rx_prev_q;

    // Clamp to the supported range: at least MIN_PRESCALE and always even.
    assign presc_eff = (Prescale < PRESC_W'(MIN_PRESCALE)) ? PRESC_W'(MIN_PRESCALE)
                                                           : {Prescale[PRESC_W-1:1], 1'b0};

    uart_rx_sampler #(
        .PRESC_W (PRESC_W)
    ) u_sampler (
        .CLK         (CLK),
        .RST         (RST),
        .run         (state_q != IDLE),
        .restart     (detect),
        .prescale    (presc_q),
        .rx_in       (RX_IN),
        .edge_last   (edge_last),
        .sampled_bit (sampled_bit)
    );

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        word_d     = word_q;
        p_data_d   = p_data_q;
        presc_d    = presc_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        par_fail_d = par_fail_q;
        vld_d      = 1'b0;
        perr_d     = 1'b0;
        serr_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (detect) begin
                    state_d    = START;
                    bit_cnt_d  = '0;
                    par_fail_d = 1'b0;
                    presc_d    = presc_eff;
                    par_en_d   = PAR_EN;
                    par_typ_d  = PAR_TYP;
                end
            end
            START: begin
                if (edge_last) begin
                    state_d = sampled_bit ? IDLE : DATA;
                end
            end
            DATA: begin
                if (edge_last) begin
                    word_d[bit_cnt_q] = sampled_bit;
                    if (bit_cnt_q == CNT_W'(WIDTH - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (edge_last) begin
                    par_fail_d = sampled_bit != ((^word_q) ^ (par_typ_q == PAR_ODD));
                    state_d    = STOP;
                end
            end
            STOP: begin
                if (edge_last) begin
                    state_d = IDLE;
                    serr_d  = !sampled_bit;
                    perr_d  = par_fail_q;
                    if (sampled_bit && !par_fail_q) begin
                        p_data_d = word_q;
                        vld_d    = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            word_q     <= '0;
            p_data_q   <= '0;
            presc_q    <= PRESC_W'(MIN_PRESCALE);
            par_en_q   <= 1'b0;
            par_typ_q  <= PAR_EVEN;
            par_fail_q <= 1'b0;
            vld_q      <= 1'b0;
            perr_q     <= 1'b0;
            serr_q     <= 1'b0;
            rx_prev_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            word_q     <= word_d;
            p_data_q   <= p_data_d;
            presc_q    <= presc_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            par_fail_q <= par_fail_d;
            vld_q      <= vld_d;
            perr_q     <= perr_d;
            serr_q     <= serr_d;
            rx_prev_q  <= RX_IN;
        end
    end

    assign P_DATA   = p_data_q;
    assign DATA_VLD = vld_q;
    assign PAR_ERR  = perr_q;
    assign STP_ERR  = serr_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: good frames, glitch rejection, parity/stop errors,
// back-to-back frames with noise, and reset mid-frame.
module tb_uart_rx_frame;
    import uart_rx_pkg::*;

    localparam int PRESC_W = 6;

    logic               CLK      = 1'b0;
    logic               RST      = 1'b0;
    logic               RX_IN    = 1'b1;
    logic               PAR_EN   = 1'b0;
    logic               PAR_TYP  = 1'b0;
    logic [PRESC_W-1:0] Prescale = 6'd8;
    logic [7:0]         P_DATA;
    logic               DATA_VLD;
    logic               PAR_ERR;
    logic               STP_ERR;

    int         checks   = 0;
    int         errors   = 0;
    int         edge_n   = 0;
    int         vld_cnt  = 0;
    int         perr_cnt = 0;
    int         serr_cnt = 0;
    int         e1;
    int         e2;
    logic [2:0] pre_flags;

    uart_rx_frame #(
        .WIDTH   (8),
        .PRESC_W (PRESC_W)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .RX_IN    (RX_IN),
        .PAR_EN   (PAR_EN),
        .PAR_TYP  (PAR_TYP),
        .Prescale (Prescale),
        .P_DATA   (P_DATA),
        .DATA_VLD (DATA_VLD),
        .PAR_ERR  (PAR_ERR),
        .STP_ERR  (STP_ERR)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) edge_n <= edge_n + 1;

    always @(negedge CLK) begin
        if (DATA_VLD) vld_cnt <= vld_cnt + 1;
        if (PAR_ERR) perr_cnt <= perr_cnt + 1;
        if (STP_ERR) serr_cnt <= serr_cnt + 1;
    end

    task automatic check_value(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Frame bits, LSB = start bit.
    function automatic logic [11:0] make_frame(input logic [7:0] d, input logic par_en,
                                               input logic par_bit, input logic stop);
        if (par_en) return {1'b0, stop, par_bit, d, 1'b0};
        return {2'b00, stop, d, 1'b0};
    endfunction

    // Called #1 after an edge; the first driven bit is sampled at the next edge (cycle 0).
    // pre_flags captures outputs during cycle N*P-1, one cycle before the result pulse.
    task automatic send_frame(input logic [11:0] bits, input int nbits, input int p,
                              input int noise_bit);
        for (int k = 0; k < nbits; k++) begin
            for (int e = 0; e < p; e++) begin
                RX_IN = (k == noise_bit && e == p / 2 - 1) ? ~bits[k] : bits[k];
                if (k == nbits - 1 && e == p - 1) pre_flags = {DATA_VLD, PAR_ERR, STP_ERR};
                @(posedge CLK);
                #1;
            end
        end
    endtask

    task automatic hold_line(input logic v, input int n);
        RX_IN = v;
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        check_value("rst_p_data", P_DATA, 8'h00);
        check_value("rst_vld", DATA_VLD, 0);
        check_value("rst_perr", PAR_ERR, 0);
        check_value("rst_serr", STP_ERR, 0);
        check_value("rst_state", dut.state_q, IDLE);
        RST = 1'b1;
        hold_line(1'b1, 4);

        // Good frame, even parity, P=8: pulse in cycle 88.
        PAR_EN = 1'b1; PAR_TYP = 1'b0; Prescale = 6'd8;
        send_frame(make_frame(8'hA5, 1'b1, 1'b0, 1'b1), 11, 8, -1);
        check_value("a5_pre", pre_flags, 3'b000);
        check_value("a5_vld", DATA_VLD, 1);
        check_value("a5_data", P_DATA, 8'hA5);
        check_value("a5_flags", {PAR_ERR, STP_ERR}, 2'b00);
        hold_line(1'b1, 1);
        check_value("a5_vld_off", DATA_VLD, 0);
        check_value("a5_vld_cnt", vld_cnt, 1);

        // Start glitch: low for 2 cycles only.
        PAR_EN = 1'b0;
        hold_line(1'b0, 2);
        hold_line(1'b1, 3);
        check_value("glitch_start", dut.state_q, START);
        hold_line(1'b1, 3);
        check_value("glitch_idle", dut.state_q, IDLE);
        hold_line(1'b1, 2);
        check_value("glitch_cnts", {vld_cnt[7:0], perr_cnt[7:0], serr_cnt[7:0]}, 24'h010000);
        send_frame(make_frame(8'h3C, 1'b0, 1'b0, 1'b1), 10, 8, -1);
        check_value("3c_vld", DATA_VLD, 1);
        check_value("3c_data", P_DATA, 8'h3C);
        hold_line(1'b1, 1);

        // Parity error, odd parity, P=16: 0x0F needs parity 1, sent 0.
        PAR_EN = 1'b1; PAR_TYP = 1'b1; Prescale = 6'd16;
        send_frame(make_frame(8'h0F, 1'b1, 1'b0, 1'b1), 11, 16, -1);
        check_value("perr_pre", pre_flags, 3'b000);
        check_value("perr_flag", PAR_ERR, 1);
        check_value("perr_vld", DATA_VLD, 0);
        check_value("perr_serr", STP_ERR, 0);
        check_value("perr_data", P_DATA, 8'h3C);
        hold_line(1'b1, 1);
        check_value("perr_off", PAR_ERR, 0);
        check_value("perr_cnt", perr_cnt, 1);

        // Stop error, line stuck low, then recovery.
        PAR_EN = 1'b0; Prescale = 6'd8;
        send_frame(make_frame(8'h55, 1'b0, 1'b0, 1'b0), 10, 8, -1);
        check_value("serr_pre", pre_flags, 3'b000);
        check_value("serr_flag", STP_ERR, 1);
        check_value("serr_perr", PAR_ERR, 0);
        check_value("serr_vld", DATA_VLD, 0);
        check_value("serr_data", P_DATA, 8'h3C);
        hold_line(1'b0, 20);
        check_value("serr_stuck_idle", dut.state_q, IDLE);
        check_value("serr_cnts", {vld_cnt[7:0], serr_cnt[7:0]}, 16'h0201);
        hold_line(1'b1, 3);
        send_frame(make_frame(8'h55, 1'b0, 1'b0, 1'b1), 10, 8, -1);
        check_value("55_vld", DATA_VLD, 1);
        check_value("55_data", P_DATA, 8'h55);
        hold_line(1'b1, 1);

        // Back-to-back at P=32, noise at edge P/2-1 of data bit 2 of the second frame.
        Prescale = 6'd32;
        send_frame(make_frame(8'h01, 1'b0, 1'b0, 1'b1), 10, 32, -1);
        check_value("b2b1_vld", DATA_VLD, 1);
        check_value("b2b1_data", P_DATA, 8'h01);
        e1 = edge_n;
        send_frame(make_frame(8'hFF, 1'b0, 1'b0, 1'b1), 10, 32, 3);
        check_value("b2b2_pre", pre_flags, 3'b000);
        check_value("b2b2_vld", DATA_VLD, 1);
        check_value("b2b2_data", P_DATA, 8'hFF);
        e2 = edge_n;
        check_value("b2b_spacing", e2 - e1, 320);
        hold_line(1'b1, 1);
        check_value("b2b_cnts", {vld_cnt[7:0], perr_cnt[7:0], serr_cnt[7:0]}, 24'h050101);

        // Reset during data bit 3 (line high then), remainder of frame stays high.
        Prescale = 6'd8;
        send_frame(make_frame(8'hF9, 1'b0, 1'b0, 1'b1), 4, 8, -1);
        hold_line(1'b1, 3);
        check_value("mid_state", dut.state_q, DATA);
        RST = 1'b0;
        @(posedge CLK);
        #1;
        check_value("mid_rst_outs", {P_DATA, DATA_VLD, PAR_ERR, STP_ERR}, 11'h000);
        check_value("mid_rst_state", dut.state_q, IDLE);
        RST = 1'b1;
        hold_line(1'b1, 44);
        check_value("mid_rest_cnts", {vld_cnt[7:0], perr_cnt[7:0], serr_cnt[7:0]},
                    24'h050101);
        PAR_EN = 1'b1; PAR_TYP = 1'b1;
        send_frame(make_frame(8'h96, 1'b1, 1'b1, 1'b1), 11, 8, -1);
        check_value("96_vld", DATA_VLD, 1);
        check_value("96_data", P_DATA, 8'h96);
        check_value("96_flags", {PAR_ERR, STP_ERR}, 2'b00);
        hold_line(1'b1, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
